// File: rtl/ram_copy.sv
// Word-by-word RAM-to-RAM copier: one READ cycle then one WRITE cycle per word,
// ascending order, with address wrap and a one-cycle DONE pulse.
module ram_copy #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src,
    input  logic [ADDR_WIDTH-1:0] dst,
    input  logic [ADDR_WIDTH:0]   len,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_st,
    output logic [DATA_WIDTH-1:0] mem_x,
    input  logic [DATA_WIDTH-1:0] mem_out,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH:0] LEN_ONE = 1;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] src_q;
    logic [ADDR_WIDTH-1:0] dst_q;
    logic [ADDR_WIDTH:0]   len_q;
    logic [ADDR_WIDTH:0]   i_q;
    logic [ADDR_WIDTH:0]   i_d;
    logic                  busy_q;
    logic                  done_q;
    logic                  st_q;
    logic [ADDR_WIDTH-1:0] addr_q;

    assign i_d = i_q + LEN_ONE;

    // Outputs are registered alongside the state, so each is loaded with the
    // value that belongs to the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            i_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            st_q    <= 1'b0;
            addr_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        src_q <= src;
                        dst_q <= dst;
                        len_q <= len;
                        i_q   <= '0;
                        if (len != '0) begin
                            state_q <= READ;
                            busy_q  <= 1'b1;
                            addr_q  <= src;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                READ: begin
                    state_q <= WRITE;
                    st_q    <= 1'b1;
                    addr_q  <= dst_q + i_q[ADDR_WIDTH-1:0];
                end
                WRITE: begin
                    i_q  <= i_d;
                    st_q <= 1'b0;
                    if (i_d == len_q) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        addr_q  <= '0;
                    end else begin
                        state_q <= READ;
                        addr_q  <= src_q + i_d[ADDR_WIDTH-1:0];
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Store enable is gated by rst directly so no word lands during reset.
    assign mem_st    = st_q & ~rst;
    assign mem_x     = st_q ? mem_out : '0;
    assign mem_addr  = addr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ram_copy.sv
// Bench for ram_copy: owns the RAM, predicts every output cycle of each copy
// from the word-copy rules, and checks final RAM contents.
module tb_ram_copy;
  localparam int DW = 8;
  localparam int AW = 6;
  localparam int W  = 3 + AW + DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] src, dst;
  logic [AW:0]   len;
  logic          busy, done, mem_st;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_x, mem_out;
  logic [1:0]    dbg_state;

  logic [DW-1:0] ram     [64];
  logic [DW-1:0] ref_mem [64];
  logic [W-1:0]  exp_q[$];

  int n_pass = 0;
  int n_total = 0;

  ram_copy #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .src(src), .dst(dst), .len(len),
    .busy(busy), .done(done), .mem_addr(mem_addr), .mem_st(mem_st),
    .mem_x(mem_x), .mem_out(mem_out), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // RAM: registered read on posedge, store on negedge
  always @(posedge clk) mem_out <= ram[mem_addr];
  always @(negedge clk) if (mem_st === 1'b1) ram[mem_addr] = mem_x;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // per-cycle output compare
  always @(negedge clk) begin
    if (rst === 1'b1) check("st_in_reset", 32'(mem_st), 32'd0);
    else if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      check("cycle_outputs", 32'({busy, done, mem_st, mem_addr, mem_x}), 32'(e));
    end else check("idle_outputs", 32'({busy, done, mem_st, mem_addr, mem_x}), 32'd0);
  end

  task automatic poke(input int a, input logic [DW-1:0] v);
    ram[a] = v;
    ref_mem[a] = v;
  endtask

  task automatic check_ram_model(input string name);
    int diffs = 0;
    for (int a = 0; a < 64; a++) if (ram[a] !== ref_mem[a]) diffs++;
    check(name, 32'(diffs), 32'd0);
  endtask

  // abort_at: cycle in which rst is raised (0 = none); poke: extra starts in cycles 3 and 9
  task automatic run_copy(input int s, input int d, input int l, input int abort_at, input bit poke);
    int ncyc;
    logic [AW-1:0] rd, wr;
    logic [DW-1:0] data;
    @(posedge clk); #1;
    src = AW'(s); dst = AW'(d); len = (AW+1)'(l); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    src = ~AW'(s); dst = ~AW'(d); len = (AW+1)'(1);
    ncyc = (abort_at == 0) ? 2 * l + 1 : abort_at - 1;
    for (int k = 0; k < l; k++) begin
      rd = AW'((s + k) % 64);
      wr = AW'((d + k) % 64);
      data = ref_mem[rd];
      if (2 * k + 1 <= ncyc) exp_q.push_back({3'b100, rd, {DW{1'b0}}});
      if (2 * k + 2 <= ncyc) begin
        exp_q.push_back({3'b101, wr, data});
        ref_mem[wr] = data;
      end
    end
    if (abort_at == 0) exp_q.push_back({3'b010, {AW{1'b0}}, {DW{1'b0}}});
    if (abort_at != 0) begin
      for (int c = 1; c < abort_at; c++) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      repeat (3) @(posedge clk);
      #1;
    end else begin
      for (int c = 1; c <= 2 * l + 3; c++) begin
        start = poke && (c == 3 || c == 9);
        if (start) begin src = 6'h05; dst = 6'h06; len = 7'd2; end
        @(posedge clk); #1;
      end
      start = 1'b0;
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; src = '0; dst = '0; len = '0;
    for (int a = 0; a < 64; a++) poke(a, DW'(a + 8'h80));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_addr", 32'(mem_addr), 32'd0);
    check("reset_st", 32'(mem_st), 32'd0);
    repeat (2) @(posedge clk);

    // basic 4-word copy
    poke(8'h10, 8'hA1); poke(8'h11, 8'hB2); poke(8'h12, 8'hC3); poke(8'h13, 8'hD4);
    run_copy(8'h10, 8'h20, 4, 0, 1'b0);
    check("basic_ram20", 32'(ram[8'h20]), 32'h0A1);
    check("basic_ram21", 32'(ram[8'h21]), 32'h0B2);
    check("basic_ram22", 32'(ram[8'h22]), 32'h0C3);
    check("basic_ram23", 32'(ram[8'h23]), 32'h0D4);
    check("basic_ram24", 32'(ram[8'h24]), 32'h0A4);
    check_ram_model("basic_model");

    // zero-length copy
    run_copy(8'h10, 8'h30, 0, 0, 1'b0);
    check_ram_model("len0_model");

    // address wrap
    poke(8'h3E, 8'h11); poke(8'h3F, 8'h22); poke(8'h00, 8'h33);
    run_copy(8'h3E, 8'h01, 3, 0, 1'b0);
    check("wrap_ram01", 32'(ram[1]), 32'h011);
    check("wrap_ram02", 32'(ram[2]), 32'h022);
    check("wrap_ram03", 32'(ram[3]), 32'h033);
    check_ram_model("wrap_model");

    // overlapping forward copy
    poke(0, 8'h55); poke(1, 8'h66);
    run_copy(0, 1, 2, 0, 1'b0);
    check("ovl_ram1", 32'(ram[1]), 32'h055);
    check("ovl_ram2", 32'(ram[2]), 32'h055);
    check_ram_model("ovl_model");

    // reset in cycle 4 aborts the copy
    poke(8'h10, 8'h01); poke(8'h11, 8'h02); poke(8'h12, 8'h03); poke(8'h13, 8'h04);
    poke(8'h20, 8'hF0); poke(8'h21, 8'hF1); poke(8'h22, 8'hF2); poke(8'h23, 8'hF3);
    run_copy(8'h10, 8'h20, 4, 4, 1'b0);
    check("abort_ram20", 32'(ram[8'h20]), 32'h001);
    check("abort_ram21", 32'(ram[8'h21]), 32'h0F1);
    check("abort_ram23", 32'(ram[8'h23]), 32'h0F3);
    check_ram_model("abort_model");

    // start pulses while busy and in DONE are ignored
    run_copy(8'h30, 8'h38, 4, 0, 1'b1);
    check("ign_ram38", 32'(ram[8'h38]), 32'h0B0);
    check("ign_ram3b", 32'(ram[8'h3B]), 32'h0B3);
    check("ign_ram06", 32'(ram[8'h06]), 32'h086);
    check_ram_model("ign_model");

    // full-size copy with wrap and self-overlap
    run_copy(0, 8'h20, 64, 0, 1'b0);
    check("full_ram20", 32'(ram[8'h20]), 32'h055);
    check("full_ram00", 32'(ram[0]), 32'h055);
    check_ram_model("full_model");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/ram_copy.md
RAM_COPY -- requirements
Module: ram_copy

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the word width of mem_x and mem_out.
REQ-002 Parameter ADDR_WIDTH, default 6, SHALL set the width of src, dst and mem_addr.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on posedge clk only.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset, sampled on posedge clk.
REQ-005 start  input  1  SHALL request a copy when high in IDLE.
REQ-006 src  input  ADDR_WIDTH  SHALL give the first source word address.
REQ-007 dst  input  ADDR_WIDTH  SHALL give the first destination word address.
REQ-008 len  input  ADDR_WIDTH+1  SHALL give the word count, 0..2**ADDR_WIDTH.
REQ-009 busy  output  1  SHALL be high while a copy is in progress.
REQ-010 done  output  1  SHALL be a one-cycle completion pulse.
REQ-011 mem_addr  output  ADDR_WIDTH  SHALL drive the RAM word address.
REQ-012 mem_st  output  1  SHALL drive the RAM store enable.
REQ-013 mem_x  output  DATA_WIDTH  SHALL drive the RAM write data.
REQ-014 mem_out  input  DATA_WIDTH  SHALL carry RAM read data, registered by the RAM on posedge from the mem_addr presented in the preceding cycle.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, READ, WRITE, DONE.
REQ-016 In IDLE with start=1 at a posedge, src, dst and len SHALL be latched into internal registers, the word index i SHALL be cleared, and the next state SHALL be READ if len!=0 and DONE if len==0.
REQ-017 In IDLE with start=0, the FSM SHALL stay in IDLE.
REQ-018 start SHALL be ignored in READ, WRITE and DONE; changes to src/dst/len after acceptance SHALL have no effect.
REQ-019 READ: mem_addr=(src_l+i) mod 2**ADDR_WIDTH, mem_st=0; next state SHALL be WRITE.
REQ-020 WRITE: mem_addr=(dst_l+i) mod 2**ADDR_WIDTH, mem_st=1, mem_x=mem_out (the word read in the preceding READ cycle); i SHALL increment, and the next state SHALL be DONE if i+1==len_l, else READ.
REQ-021 Each word SHALL take exactly 2 cycles; a copy of len words SHALL hold busy high for exactly 2*len cycles.
REQ-022 DONE SHALL last one cycle with done=1 and busy=0; the next state SHALL be IDLE.
REQ-023 busy SHALL be 1 in READ and WRITE, and 0 in IDLE and DONE; done SHALL be 1 only in DONE.
REQ-024 In IDLE and DONE: mem_st=0, mem_addr=0, mem_x=0.
REQ-025 mem_addr, mem_st and mem_x SHALL be derived only from registered state and mem_out, so they are stable from posedge to the following negedge (the RAM stores on negedge).
REQ-026 Address arithmetic SHALL wrap modulo 2**ADDR_WIDTH; len=2**ADDR_WIDTH SHALL copy every word once.
REQ-027 Copy order SHALL be ascending i; for overlapping ranges with dst>src, already-written words SHALL be re-read as written (no overlap correction).
REQ-028 mem_st SHALL be forced to 0 combinationally in any cycle where rst=1, so that no RAM write occurs during reset.

Reset
REQ-029 On posedge with rst=1: state=IDLE, i=0, latched registers=0; busy=0, done=0, mem_st=0, mem_addr=0, mem_x=0 from the next cycle on.
REQ-030 rst during READ/WRITE SHALL abort the copy with no done pulse; words already written SHALL remain written.
REQ-031 rst SHALL take priority over start in the same cycle.

Verification
REQ-032 Preload RAM[0x10..0x13]=A1,B2,C3,D4; start with src=0x10, dst=0x20, len=4 at edge E0 -> busy in cycles 1..8, done only in cycle 9, RAM[0x20..0x23]=A1,B2,C3,D4, mem_st high only in cycles 2,4,6,8.
REQ-033 len=0 -> busy never high, done in cycle 1, no write.
REQ-034 src=0x3E, dst=0x01, len=3 (ADDR_WIDTH=6) -> reads from 0x3E,0x3F,0x00; writes to 0x01,0x02,0x03.
REQ-035 Overlap: RAM[0..1]=55,66, src=0, dst=1, len=2 -> RAM[1]=55, RAM[2]=55.
REQ-036 Assert rst in cycle 4 of a 4-word copy -> no write in cycle 4, busy=0 and done=0 from cycle 5, RAM[0x20] written and RAM[0x21..0x23] unchanged.
REQ-037 Pulse start again in cycles 3 and 9 with different operands -> both ignored; the FSM returns to IDLE after DONE.
